// File: rtl/fpmul_pkg.sv
// Shared definitions for the single-precision multiplier controller.
// FPMUL_SPECIAL_CASE_EN adds the SPECIAL state used by the operand bypass.
package fpmul_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int WORD_W = SIGN_W + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;
  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-2:0] INF_MAG = 31'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MULT,
    NORM,
    ROUND,
    DONE
`ifdef FPMUL_SPECIAL_CASE_EN
    , SPECIAL
`endif
  } state_t;

  // Which bypass value to return for a special operand pair.
  typedef enum logic [1:0] {
    BYP_NONE,
    BYP_QNAN,
    BYP_INF,
    BYP_ZERO
  } bypass_t;

endpackage

// File: rtl/fpmul_operand_classify.sv
// Flags an IEEE-754 single operand as zero (denormals flushed), infinity or NaN.
// Present only when FPMUL_SPECIAL_CASE_EN is defined.
`ifdef FPMUL_SPECIAL_CASE_EN
module fpmul_operand_classify
  import fpmul_pkg::*;
(
  input  logic [WORD_W-1:0] operand,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  logic [EXP_W-1:0]  exp_field;
  logic [FRAC_W-1:0] frac_field;
  logic              unused_sign;

  assign exp_field   = operand[WORD_W-2:FRAC_W];
  assign frac_field  = operand[FRAC_W-1:0];
  assign unused_sign = operand[WORD_W-1];

  assign is_zero = (exp_field == '0);
  assign is_inf  = (exp_field == EXP_MAX) && (frac_field == '0);
  assign is_nan  = (exp_field == EXP_MAX) && (frac_field != '0);

endmodule
`endif

// File: rtl/fpmul_control_unit.sv
// Start/busy/done sequencer driving the fp multiplier datapath through LOAD-MULT-NORM-ROUND.
// FPMUL_SPECIAL_CASE_EN enables the zero/inf/NaN bypass through the SPECIAL state.
module fpmul_control_unit
  import fpmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic              overflow,
  output logic [WORD_W-1:0] dp_A,
  output logic [WORD_W-1:0] dp_B,
  output logic              dp_mux_en_reg,
  output logic              dp_enable_reg,
  output logic              dp_inc_shift_en,
  output logic              dp_mux_en_rounding,
  output logic              dp_enable_rounding,
  output logic              dp_no_start,
  input  logic              dp_MLB_significand_mult,
  input  logic              dp_MLB_exp_inc,
  input  logic              dp_overflow_flag,
  input  logic [WORD_W-1:0] dp_result
);

  state_t state, next_state;
  logic   norm_q;
  logic   exp_q;

`ifdef FPMUL_SPECIAL_CASE_EN
  logic        a_zero, a_inf, a_nan;
  logic        b_zero, b_inf, b_nan;
  logic        sign;
  bypass_t     bypass_sel, bypass_q;
  logic [WORD_W-1:0] bypass_value;

  fpmul_operand_classify u_classify_a (
    .operand (op_a),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan)
  );

  fpmul_operand_classify u_classify_b (
    .operand (op_b),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan)
  );

  // NaN and inf*zero dominate; then infinity; then a (flushed) zero.
  always_comb begin
    bypass_sel = BYP_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      bypass_sel = BYP_QNAN;
    else if (a_inf || b_inf)
      bypass_sel = BYP_INF;
    else if (a_zero || b_zero)
      bypass_sel = BYP_ZERO;
  end

  assign sign = dp_A[WORD_W-1] ^ dp_B[WORD_W-1];

  always_comb begin
    bypass_value = '0;
    case (bypass_q)
      BYP_QNAN: bypass_value = QNAN;
      BYP_INF:  bypass_value = {sign, INF_MAG};
      BYP_ZERO: bypass_value = {sign, {(WORD_W-1){1'b0}}};
      default:  bypass_value = '0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      dp_A     <= '0;
      dp_B     <= '0;
      norm_q   <= 1'b0;
      exp_q    <= 1'b0;
`ifdef FPMUL_SPECIAL_CASE_EN
      bypass_q <= BYP_NONE;
`endif
    end else begin
      state <= next_state;
      // done is registered so it lines up with the freshly registered result.
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            dp_A   <= op_a;
            dp_B   <= op_b;
            norm_q <= 1'b0;
            exp_q  <= 1'b0;
            busy   <= 1'b1;
`ifdef FPMUL_SPECIAL_CASE_EN
            bypass_q <= bypass_sel;
`endif
          end
        end
        MULT: norm_q <= dp_MLB_significand_mult;
        NORM: exp_q  <= dp_MLB_exp_inc;
        DONE: begin
          busy <= 1'b0;
`ifdef FPMUL_SPECIAL_CASE_EN
          if (bypass_q != BYP_NONE) begin
            result   <= bypass_value;
            overflow <= 1'b0;
          end else begin
            result   <= dp_result;
            overflow <= dp_overflow_flag | exp_q;
          end
`else
          result   <= dp_result;
          overflow <= dp_overflow_flag | exp_q;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state         = state;
    dp_no_start        = 1'b1;
    dp_mux_en_rounding = 1'b1;
    dp_mux_en_reg      = 1'b0;
    dp_enable_reg      = 1'b0;
    dp_inc_shift_en    = 1'b0;
    dp_enable_rounding = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef FPMUL_SPECIAL_CASE_EN
          next_state = (bypass_sel != BYP_NONE) ? SPECIAL : LOAD;
`else
          next_state = LOAD;
`endif
        end
      end
      LOAD: begin
        dp_enable_reg = 1'b1;
        next_state    = MULT;
      end
      MULT: begin
        dp_enable_reg = 1'b1;
        dp_mux_en_reg = 1'b1;
        next_state    = NORM;
      end
      NORM: begin
        dp_inc_shift_en = norm_q;
        next_state      = ROUND;
      end
      ROUND: begin
        dp_inc_shift_en    = norm_q;
        dp_enable_rounding = 1'b1;
        dp_no_start        = 1'b0;
        dp_mux_en_rounding = 1'b0;
        next_state         = DONE;
      end
      DONE: next_state = IDLE;
`ifdef FPMUL_SPECIAL_CASE_EN
      SPECIAL: next_state = DONE;
`endif
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpmul_control_unit.sv
// Directed bench for fpmul_control_unit with a tiny datapath responder.
// Special-operand vectors run only when FPMUL_SPECIAL_CASE_EN is defined.
module tb_fpmul_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done, overflow;
  logic [31:0] result, dp_A, dp_B;
  logic        dp_mux_en_reg, dp_enable_reg, dp_inc_shift_en;
  logic        dp_mux_en_rounding, dp_enable_rounding, dp_no_start;
  logic        dp_MLB_significand_mult, dp_MLB_exp_inc, dp_overflow_flag;
  logic [31:0] dp_result;

  logic        mlb_v, exp_inc_v, ovf_v;
  logic [31:0] dp_result_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // The significand MSB is only presented while the datapath captures the product.
  assign dp_MLB_significand_mult = mlb_v & dp_enable_reg & dp_mux_en_reg;
  assign dp_MLB_exp_inc          = exp_inc_v;
  assign dp_overflow_flag        = ovf_v;
  assign dp_result               = dp_result_v;

  fpmul_control_unit dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .start                   (start),
    .op_a                    (op_a),
    .op_b                    (op_b),
    .busy                    (busy),
    .done                    (done),
    .result                  (result),
    .overflow                (overflow),
    .dp_A                    (dp_A),
    .dp_B                    (dp_B),
    .dp_mux_en_reg           (dp_mux_en_reg),
    .dp_enable_reg           (dp_enable_reg),
    .dp_inc_shift_en         (dp_inc_shift_en),
    .dp_mux_en_rounding      (dp_mux_en_rounding),
    .dp_enable_rounding      (dp_enable_rounding),
    .dp_no_start             (dp_no_start),
    .dp_MLB_significand_mult (dp_MLB_significand_mult),
    .dp_MLB_exp_inc          (dp_MLB_exp_inc),
    .dp_overflow_flag        (dp_overflow_flag),
    .dp_result               (dp_result)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Issues one operation at the next edge and checks every cycle up to the done pulse.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic mlb, input logic expi, input logic ovf,
                               input logic [31:0] dpr, input logic exp_ovf);
    mlb_v = mlb; exp_inc_v = expi; ovf_v = ovf; dp_result_v = dpr;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_dp_A", dp_A, a);
    checkOutput("load_dp_B", dp_B, b);
    checkOutput("load_en_reg", dp_enable_reg, 1);
    checkOutput("load_mux_reg", dp_mux_en_reg, 0);
    @(negedge clk);
    checkOutput("mult_en_reg", dp_enable_reg, 1);
    checkOutput("mult_mux_reg", dp_mux_en_reg, 1);
    checkOutput("mult_done", done, 0);
    @(negedge clk);
    checkOutput("norm_en_reg", dp_enable_reg, 0);
    checkOutput("norm_shift", dp_inc_shift_en, mlb);
    @(negedge clk);
    checkOutput("round_shift", dp_inc_shift_en, mlb);
    checkOutput("round_en_rnd", dp_enable_rounding, 1);
    checkOutput("round_no_start", dp_no_start, 0);
    checkOutput("round_mux_rnd", dp_mux_en_rounding, 0);
    @(negedge clk);
    checkOutput("donest_busy", busy, 1);
    checkOutput("donest_done", done, 0);
    checkOutput("donest_en_rnd", dp_enable_rounding, 0);
    @(negedge clk);
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_result", result, dpr);
    checkOutput("done_overflow", overflow, exp_ovf);
    checkOutput("done_no_start", dp_no_start, 1);
    @(negedge clk);
    checkOutput("after_done", done, 0);
    checkOutput("after_result", result, dpr);
  endtask

`ifdef FPMUL_SPECIAL_CASE_EN
  task automatic applySpecial(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected);
    mlb_v = 1'b1; exp_inc_v = 1'b1; ovf_v = 1'b1; dp_result_v = 32'h1234_5678;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("sp_busy", busy, 1);
    checkOutput("sp_no_start", dp_no_start, 1);
    checkOutput("sp_mux_rnd", dp_mux_en_rounding, 1);
    checkOutput("sp_en_reg", dp_enable_reg, 0);
    @(negedge clk);
    checkOutput("sp_done_st_en_reg", dp_enable_reg, 0);
    checkOutput("sp_done_st_en_rnd", dp_enable_rounding, 0);
    checkOutput("sp_done_st_done", done, 0);
    @(negedge clk);
    checkOutput("sp_done", done, 1);
    checkOutput("sp_result", result, expected);
    checkOutput("sp_overflow", overflow, 0);
  endtask
`endif

  initial begin
    int extra;
    reset_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    mlb_v = 1'b0; exp_inc_v = 1'b0; ovf_v = 1'b0; dp_result_v = '0;
    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_no_start", dp_no_start, 1);
    checkOutput("rst_mux_rnd", dp_mux_en_rounding, 1);
    checkOutput("rst_en_reg", dp_enable_reg, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] 2.0 x 3.0");
    applyStimulus(32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 32'h40C0_0000, 1'b0);
    $display("[TB] 1.5 x 1.5");
    applyStimulus(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 1'b0, 1'b0, 32'h4010_0000, 1'b0);
    $display("[TB] exponent overflow");
    applyStimulus(32'h7F00_0000, 32'h7F00_0000, 1'b0, 1'b1, 1'b0, 32'h7F80_0000, 1'b1);
    $display("[TB] datapath overflow flag");
    applyStimulus(32'h7E80_0000, 32'h4100_0000, 1'b1, 1'b0, 1'b1, 32'h7F80_0000, 1'b1);
    $display("[TB] exp_q cleared on new request");
    applyStimulus(32'h3F80_0000, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 32'hC000_0000, 1'b0);

    $display("[TB] start during MULT is ignored");
    mlb_v = 1'b0; exp_inc_v = 1'b0; ovf_v = 1'b0; dp_result_v = 32'h4080_0000;
    @(negedge clk);
    start = 1'b1; op_a = 32'h4000_0000; op_b = 32'h4000_0000;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op_a = 32'h4100_0000; op_b = 32'h4200_0000;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ign_dp_A", dp_A, 32'h4000_0000);
    checkOutput("ign_dp_B", dp_B, 32'h4000_0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ign_done", done, 1);
    checkOutput("ign_result", result, 32'h4080_0000);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checkOutput("ign_no_second_op", extra, 0);

    $display("[TB] reset during ROUND");
    mlb_v = 1'b1; dp_result_v = 32'h4110_0000;
    @(negedge clk);
    start = 1'b1; op_a = 32'h4040_0000; op_b = 32'h4040_0000;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    checkOutput("pre_rst_en_rnd", dp_enable_rounding, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_result", result, 32'h0);
    checkOutput("mid_rst_overflow", overflow, 0);
    checkOutput("mid_rst_en_rnd", dp_enable_rounding, 0);
    checkOutput("mid_rst_dp_A", dp_A, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checkOutput("rst_no_done", extra, 0);
    applyStimulus(32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 32'h40C0_0000, 1'b0);

`ifdef FPMUL_SPECIAL_CASE_EN
    $display("[TB] special operands");
    applySpecial(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);
    applySpecial(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    applySpecial(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    applySpecial(32'h8000_0000, 32'h4000_0000, 32'h8000_0000);
    applyStimulus(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 1'b0, 1'b0, 32'h4010_0000, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpmul_control_unit.md
# fpmul_control_unit

Sequencing controller that sits directly upstream of the single-precision floating-point multiplier datapath. It accepts operands through a start/busy/done handshake and latches them. It then drives the datapath's register-load, normalise and rounding controls in a fixed schedule and returns the registered IEEE-754 result with an overflow flag. Optionally, it detects special operands (zero, infinity, NaN) and bypasses the datapath for them.

## Interface
- No parameters; widths are fixed by the shared package (32-bit single precision).
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op_a, op_b  in  32  IEEE-754 operands; sampled with start
- busy  out  1  high from the cycle after start is accepted until DONE completes
- done  out  1  one-cycle pulse; result and overflow are valid
- result  out  32  registered product; held until the next done
- overflow  out  1  registered; held with result
- dp_A, dp_B  out  32  latched operands to the datapath
- dp_mux_en_reg, dp_enable_reg, dp_inc_shift_en, dp_mux_en_rounding, dp_enable_rounding, dp_no_start  out  1  datapath controls
- dp_MLB_significand_mult, dp_MLB_exp_inc, dp_overflow_flag  in  1  datapath status
- dp_result  in  32  datapath rounded result

## Operation
- States: IDLE, LOAD, MULT, NORM, ROUND, DONE, plus SPECIAL (only when the macro is defined).
- Datapath control outputs by state:
  - IDLE: dp_no_start=1, dp_mux_en_rounding=1, all other dp controls 0. On start, latch op_a/op_b into dp_A/dp_B, clear norm_q/exp_q, go to LOAD (or to SPECIAL if a special case is detected).
  - LOAD: dp_enable_reg=1, dp_mux_en_reg=0. The datapath registers capture the operands.
  - MULT: dp_enable_reg=1, dp_mux_en_reg=1. norm_q <= dp_MLB_significand_mult. The datapath captures exp_sum and the 48-bit product.
  - NORM: dp_enable_reg=0, dp_inc_shift_en=norm_q. exp_q <= dp_MLB_exp_inc (9-bit exponent out of range).
  - ROUND: dp_inc_shift_en=norm_q, dp_enable_rounding=1, dp_no_start=0, dp_mux_en_rounding=0.
  - DONE: result <= dp_result, overflow <= dp_overflow_flag | exp_q, done=1, busy stays 1 for this cycle. Next state is IDLE.
- start is ignored while busy=1. There is no queueing; a request is lost if the requester does not hold start until IDLE.
- sign = op_a[31] ^ op_b[31], computed from the latched operands.
- Reset (any state, asynchronous):
  - state=IDLE.
  - busy, done, overflow, norm_q, exp_q = 0.
  - result, dp_A, dp_B = 32'h0.
  - dp controls take their IDLE values.

## Timing
- Normal latency: start sampled at edge N. done is high during the cycle after edge N+5, together with the new result and overflow.
- Special bypass latency: done is high during the cycle after edge N+2.
- Back-to-back operation: the earliest next start is sampled in the IDLE cycle after DONE, giving a 6-cycle issue interval.
- If reset_n is deasserted mid-operation, the operation is discarded and no done is produced.

## Configuration
- FPMUL_SPECIAL_CASE_EN defined:
  - In IDLE, classify the operands. exp=0 is treated as zero (denormals flushed). exp=255 with frac=0 is inf; exp=255 with frac≠0 is NaN.
  - Any NaN operand, or inf×zero, gives 32'h7FC00000.
  - inf×nonzero gives {sign, 8'hFF, 23'h0}.
  - zero×finite gives {sign, 31'h0}.
  - The FSM goes IDLE→SPECIAL→DONE. In DONE, the bypass value is registered and overflow=0. The datapath controls stay at IDLE values.
- FPMUL_SPECIAL_CASE_EN undefined: the SPECIAL state and the classifier are absent, and every operand pair takes the full datapath path.

## Structure
- fpmul_pkg: state enum, SIGN/EXP/FRAC widths, EXP_MAX=8'hFF, QNAN=32'h7FC00000, and the INF magnitude constant.
- One sub-module, fpmul_operand_classify: combinational; takes a 32-bit input and outputs is_zero, is_inf and is_nan. It is instantiated twice and only under the macro.

## Test plan
- 0x40000000 × 0x40400000 (2.0×3.0) → result 0x40C00000, overflow 0; done 5 cycles after start; dp_inc_shift_en stays 0.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5) → result 0x40100000; dp_inc_shift_en=1 in NORM and ROUND.
- 0x7F000000 × 0x7F000000 → overflow=1 at done.
- With the macro defined:
  - 0x7FC00000 × 0x3F800000 → 0x7FC00000.
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - Each done 2 cycles after start, with the dp controls unchanged from IDLE.
- start pulsed during MULT with a different operand pair → ignored; the result is from the first pair only.
- reset_n low during ROUND → busy, done, result and overflow go to 0 immediately; the next start completes normally.
